// File: rtl/fft_axis_in_loader_pkg.sv
// Shared types and helpers for the FFT ingress loader.
// Bank lifecycle, loader FSM encoding and bit-reversal.
package fft_axis_in_loader_pkg;

    localparam int DATA_WDT = 32;
    localparam int FFT_LOG2 = 10;
    localparam int FFT_N    = 2**FFT_LOG2;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL,
        BUSY
    } bank_state_t;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        STALL
    } loader_fsm_t;

    // Reverses the low wdt bits of addr; upper bits come back zero.
    function automatic logic [15:0] bitrev(
        input logic [15:0] addr,
        input int unsigned wdt
    );
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = addr[15-i];
        end
        return r >> (16 - wdt);
    endfunction

endpackage

// File: rtl/fft_bank_tracker.sv
// Two-entry ping-pong bank state with oldest-first frame offer.
// frame_valid/frame_bank are registered and held until accepted.
module fft_bank_tracker
    import fft_axis_in_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill,
    input  logic        done,
    input  logic        drop,
    input  logic        wr_bank,
    input  logic        frame_ready,
    input  logic        core_release,
    input  logic        core_release_bank,
    output bank_state_t bank_st [2],
    output logic        frame_valid,
    output logic        frame_bank,
    output logic [15:0] frame_cnt
);

    bank_state_t st_n [2];
    logic        acc;
    logic        newest;
    logic        last_done;
    logic        bank_n;
    logic        any_full_n;

    always_comb begin
        st_n   = bank_st;
        acc    = frame_valid & frame_ready;
        newest = done ? wr_bank : last_done;
        for (int b = 0; b < 2; b++) begin
            unique case (bank_st[b])
                FREE, FILLING: begin
                    if (wr_bank == b[0]) begin
                        if (drop)      st_n[b] = FREE;
                        else if (done) st_n[b] = FULL;
                        else if (fill) st_n[b] = FILLING;
                    end
                end
                FULL: begin
                    if (acc && frame_bank == b[0])
                        st_n[b] = BUSY;
                end
                BUSY: begin
                    if (core_release &&
                        core_release_bank == b[0])
                        st_n[b] = FREE;
                end
                default: st_n[b] = FREE;
            endcase
        end
        any_full_n = (st_n[0] == FULL) ||
                     (st_n[1] == FULL);
        // An unaccepted offer is never swapped out.
        bank_n = frame_bank;
        if (frame_valid && !acc)
            bank_n = frame_bank;
        else if (st_n[0] == FULL && st_n[1] == FULL)
            bank_n = ~newest;
        else if (st_n[0] == FULL)
            bank_n = 1'b0;
        else if (st_n[1] == FULL)
            bank_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0]  <= FREE;
            bank_st[1]  <= FREE;
            last_done   <= 1'b0;
            frame_valid <= 1'b0;
            frame_bank  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            bank_st     <= st_n;
            last_done   <= newest;
            frame_valid <= any_full_n;
            frame_bank  <= bank_n;
            if (acc)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/fft_axis_in_loader.sv
// AXI-Stream ingress: writes frames into a ping-pong input memory
// in bit-reversed order and hands full banks to the FFT core.
module fft_axis_in_loader
    import fft_axis_in_loader_pkg::*;
#(
    parameter int DATA_WDT  = fft_axis_in_loader_pkg::DATA_WDT,
    parameter int FFT_LOG2  = fft_axis_in_loader_pkg::FFT_LOG2,
    parameter int BITREV_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_WDT-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic                mem_wr_en,
    output logic                mem_wr_bank,
    output logic [FFT_LOG2-1:0] mem_wr_addr,
    output logic [DATA_WDT-1:0] mem_wr_data,
    output logic                frame_valid,
    output logic                frame_bank,
    input  logic                frame_ready,
    input  logic                core_release,
    input  logic                core_release_bank,
    output logic                err_tlast_early,
    output logic                err_tlast_missing,
    input  logic                err_clr,
    output logic [15:0]         frame_cnt
);

    localparam logic [FFT_LOG2-1:0] LAST_BEAT = '1;

    loader_fsm_t         fsm_q, fsm_n;
    logic [FFT_LOG2-1:0] beat_q, beat_n;
    logic                wr_bank_q, wr_bank_n;
    logic                armed_q;
    bank_state_t         bank_st [2];
    logic                wr_free;
    logic                oth;
    logic                oth_free_n;
    logic                fill, done, drop;
    logic                set_early, set_missing;
    logic [FFT_LOG2-1:0] addr_n;

    assign wr_free = (bank_st[wr_bank_q] == FREE) ||
                     (bank_st[wr_bank_q] == FILLING);
    assign oth     = ~wr_bank_q;
    // A release landing with completion avoids a stall cycle.
    assign oth_free_n = (bank_st[oth] == FREE) ||
                        (bank_st[oth] == BUSY &&
                         core_release &&
                         core_release_bank == oth);

    always_comb begin
        fsm_n         = fsm_q;
        beat_n        = beat_q;
        wr_bank_n     = wr_bank_q;
        s_axis_tready = 1'b0;
        fill          = 1'b0;
        done          = 1'b0;
        drop          = 1'b0;
        set_early     = 1'b0;
        set_missing   = 1'b0;
        unique case (fsm_q)
            FILL: begin
                s_axis_tready = armed_q & wr_free;
                if (s_axis_tvalid && s_axis_tready) begin
                    fill = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        done      = 1'b1;
                        beat_n    = '0;
                        wr_bank_n = ~wr_bank_q;
                        if (!s_axis_tlast) begin
                            set_missing = 1'b1;
                            fsm_n       = DRAIN;
                        end else if (!oth_free_n) begin
                            fsm_n = STALL;
                        end
                    end else if (s_axis_tlast) begin
                        drop      = 1'b1;
                        set_early = 1'b1;
                        beat_n    = '0;
                    end else begin
                        beat_n = beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                s_axis_tready = armed_q;
                if (s_axis_tvalid && s_axis_tlast)
                    fsm_n = FILL;
            end
            STALL: begin
                if (bank_st[wr_bank_q] == FREE)
                    fsm_n = FILL;
            end
            default: fsm_n = FILL;
        endcase
    end

    assign addr_n = (BITREV_EN != 0) ?
        FFT_LOG2'(bitrev(16'(beat_q), FFT_LOG2)) :
        beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q             <= FILL;
            beat_q            <= '0;
            wr_bank_q         <= 1'b0;
            armed_q           <= 1'b0;
            mem_wr_en         <= 1'b0;
            mem_wr_bank       <= 1'b0;
            mem_wr_addr       <= '0;
            mem_wr_data       <= '0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
        end else begin
            fsm_q     <= fsm_n;
            beat_q    <= beat_n;
            wr_bank_q <= wr_bank_n;
            armed_q   <= 1'b1;
            mem_wr_en <= fill;
            if (fill) begin
                mem_wr_bank <= wr_bank_q;
                mem_wr_addr <= addr_n;
                mem_wr_data <= s_axis_tdata;
            end
            if (set_early)
                err_tlast_early <= 1'b1;
            else if (err_clr)
                err_tlast_early <= 1'b0;
            if (set_missing)
                err_tlast_missing <= 1'b1;
            else if (err_clr)
                err_tlast_missing <= 1'b0;
        end
    end

    fft_bank_tracker u_tracker (
        .clk               (clk),
        .rst_n             (rst_n),
        .fill              (fill),
        .done              (done),
        .drop              (drop),
        .wr_bank           (wr_bank_q),
        .frame_ready       (frame_ready),
        .core_release      (core_release),
        .core_release_bank (core_release_bank),
        .bank_st           (bank_st),
        .frame_valid       (frame_valid),
        .frame_bank        (frame_bank),
        .frame_cnt         (frame_cnt)
    );

endmodule

// File: tb/tb_fft_axis_in_loader.sv
// Scoreboard bench for fft_axis_in_loader with a frame-level
// reference model and a randomized core/back-pressure model.
module tb_fft_axis_in_loader;

    localparam int LOG = 10;
    localparam int N   = 1 << LOG;

    typedef struct packed {
        logic        bank;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        bank;
        logic [31:0] sum;
    } frm_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        mem_wr_en;
    logic        mem_wr_bank;
    logic [9:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        frame_valid;
    logic        frame_bank;
    logic        frame_ready;
    logic        core_release;
    logic        core_release_bank;
    logic        err_tlast_early;
    logic        err_tlast_missing;
    logic        err_clr;
    logic [15:0] frame_cnt;

    fft_axis_in_loader #(
        .DATA_WDT  (32),
        .FFT_LOG2  (LOG),
        .BITREV_EN (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_bank       (mem_wr_bank),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .frame_valid       (frame_valid),
        .frame_bank        (frame_bank),
        .frame_ready       (frame_ready),
        .core_release      (core_release),
        .core_release_bank (core_release_bank),
        .err_tlast_early   (err_tlast_early),
        .err_tlast_missing (err_tlast_missing),
        .err_clr           (err_clr),
        .frame_cnt         (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   dead   = 0;
    wr_t  exp_q [$];
    frm_t frm_q [$];
    logic acc_q [$];
    logic [31:0] mem [2][N];

    // reference model of the loader's framing rules
    int          m_beat;
    logic        m_bank;
    logic        m_drain;
    logic [31:0] m_sum;

    bit auto_rel   = 1;
    bit rand_ready = 0;
    int rel_grant  = 0;
    int rel_done   = 0;
    int rel_wait   = 0;

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LOG; i++)
            r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic model_reset();
        m_beat  = 0;
        m_bank  = 1'b0;
        m_drain = 1'b0;
        m_sum   = '0;
    endtask

    task automatic put(input logic [31:0] d,
                       input logic last);
        int   t = 0;
        logic hs;
        wr_t  w;
        frm_t f;
        if (dead) return;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        forever begin
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            if (hs) break;
            t++;
            if (t > 5000) begin
                fail("tready_timeout");
                dead = 1;
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        s_axis_tvalid = 1'b0;
        if (m_drain) begin
            if (last) m_drain = 1'b0;
        end else begin
            w.bank = m_bank;
            w.addr = 10'(brev(m_beat));
            w.data = d;
            exp_q.push_back(w);
            m_sum += d * 32'(m_beat + 1);
            if (m_beat == N - 1) begin
                f.bank = m_bank;
                f.sum  = m_sum;
                frm_q.push_back(f);
                m_bank = ~m_bank;
                m_beat = 0;
                m_sum  = '0;
                if (!last) m_drain = 1'b1;
            end else if (last) begin
                m_beat = 0;
                m_sum  = '0;
            end else begin
                m_beat++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        if (dead) return;
        while (frm_q.size() != 0 || exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            if (++t > 20000) begin
                fail("drain_timeout");
                dead = 1;
                return;
            end
        end
        idle(2);
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        err_clr       = 1'b0;
        rst_n         = 1'b0;
        #2;
        chk("rst_ctl",
            {s_axis_tready, mem_wr_en, mem_wr_bank,
             frame_valid, frame_bank, err_tlast_early,
             err_tlast_missing, frame_cnt}, '0);
        chk("rst_wdata", {mem_wr_addr, mem_wr_data}, '0);
        idle(3);
        rst_n = 1'b1;
        model_reset();
        idle(2);
        chk("tready_after_rst", s_axis_tready, 1);
        chk("no_stale_valid", frame_valid, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(1);
    endtask

    // write/frame monitor
    always @(negedge clk) begin
        wr_t  g, e;
        frm_t f;
        logic [31:0] s;
        if (!rst_n) begin
            exp_q.delete();
            frm_q.delete();
            acc_q.delete();
        end else begin
            if (mem_wr_en) begin
                g = {mem_wr_bank, mem_wr_addr, mem_wr_data};
                if (exp_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    chk("write", 64'(g), 64'(e));
                end
                mem[mem_wr_bank][mem_wr_addr] = mem_wr_data;
            end
            if (frame_valid && frame_ready) begin
                acc_q.push_back(frame_bank);
                if (frm_q.size() == 0) begin
                    fail("unexpected_frame");
                end else begin
                    f = frm_q.pop_front();
                    chk("frame_bank", frame_bank, f.bank);
                    s = '0;
                    for (int i = 0; i < N; i++)
                        s += mem[f.bank][brev(i)] * 32'(i + 1);
                    chk("frame_sum", s, f.sum);
                end
            end
        end
    end

    // core model: frame_ready and delayed bank releases
    initial begin
        core_release      = 1'b0;
        core_release_bank = 1'b0;
        frame_ready       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_release = 1'b0;
            frame_ready  = rand_ready ?
                ($urandom_range(0, 2) == 0) : 1'b1;
            if (rel_wait > 0) begin
                rel_wait--;
            end else if (acc_q.size() > 0 &&
                         (auto_rel || rel_done < rel_grant)) begin
                core_release      = 1'b1;
                core_release_bank = acc_q.pop_front();
                rel_done++;
                rel_wait = auto_rel ? $urandom_range(0, 40) : 0;
            end
        end
    end

    initial begin
        int t;
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        err_clr       = 1'b0;
        model_reset();
        idle(1);

        // single ramp frame
        do_reset();
        for (int i = 0; i < N; i++) begin
            put(32'(i), i == N - 1);
            if (i == 1) chk("addr_beat1", mem_wr_addr, 512);
            if (i == 2) chk("addr_beat2", mem_wr_addr, 256);
        end
        chk("t1_valid", {frame_valid, frame_bank}, 2'b10);
        wait_idle();
        chk("t1_cnt", frame_cnt, 1);
        chk("t1_err", {err_tlast_early, err_tlast_missing}, 0);

        // three frames with release withheld
        do_reset();
        auto_rel = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++)
                put($urandom, i == N - 1);
        idle(2);
        chk("stall_tready", s_axis_tready, 0);
        rel_grant = rel_done + 1;
        t = 0;
        while (!s_axis_tready && t < 20) begin
            idle(1);
            t++;
        end
        chk("release_tready", s_axis_tready, 1);
        for (int i = 0; i < N; i++)
            put($urandom, i == N - 1);
        wait_idle();
        chk("t2_cnt", frame_cnt, 3);
        auto_rel = 1;

        // early tlast, with err_clr on the same edge
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i == 99) err_clr = 1'b1;
            put($urandom, i == 99);
            err_clr = 1'b0;
        end
        chk("early_set", err_tlast_early, 1);
        idle(3);
        chk("early_no_valid", frame_valid, 0);
        chk("early_cnt", frame_cnt, 0);
        for (int i = 0; i < N; i++)
            put($urandom, i == N - 1);
        wait_idle();
        chk("early_next_cnt", frame_cnt, 1);
        chk("early_sticky", err_tlast_early, 1);
        pulse_clr();
        chk("early_clr", err_tlast_early, 0);

        // missing tlast, five drained beats
        do_reset();
        for (int i = 0; i < N; i++)
            put($urandom, 1'b0);
        chk("missing_set", err_tlast_missing, 1);
        for (int i = 0; i < 5; i++)
            put($urandom, i == 4);
        wait_idle();
        chk("missing_cnt", frame_cnt, 1);
        chk("missing_no_early", err_tlast_early, 0);
        pulse_clr();
        chk("missing_clr", err_tlast_missing, 0);

        // reset mid-frame
        do_reset();
        for (int i = 0; i < 500; i++)
            put($urandom, 1'b0);
        do_reset();
        for (int i = 0; i < N; i++)
            put($urandom, i == N - 1);
        wait_idle();
        chk("post_rst_cnt", frame_cnt, 1);

        // random traffic and core timing
        do_reset();
        rand_ready = 1;
        for (int f = 0; f < 20; f++)
            for (int i = 0; i < N; i++) begin
                while ($urandom_range(0, 1) == 1) idle(1);
                put($urandom, i == N - 1);
            end
        wait_idle();
        chk("rand_cnt", frame_cnt, 20);
        chk("rand_err", {err_tlast_early, err_tlast_missing}, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
